fpu_exec_sequencer: RTL

Issue/writeback stage directly upstream and downstream of the FPU ALU execution element. Accepts one decoded FP instruction at a time, reads operands from a 32x32 FP register file it owns, and drives the element's inst_num/fs/ft. It holds the element in reset between operations, waits for `completed`, and writes the result back to the destination register. A cycle timeout catches operations that never complete, such as unimplemented SQRT.S.

---
 rtl/fpu_exec_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fpu_exec_sequencer.sv
// Issue/writeback sequencer around the FPU ALU element.
// Owns the 32x32 FP register file and bounds every RUN with a timeout.
module fpu_exec_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_inst_num,
  input  logic [4:0]  req_fd,
  input  logic [4:0]  req_fs,
  input  logic [4:0]  req_ft,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_error,
  output logic [31:0] resp_data,
  output logic        elem_reset,
  output logic [5:0]  elem_inst_num,
  output logic [31:0] elem_fs,
  output logic [31:0] elem_ft,
  input  logic        elem_completed,
  input  logic [31:0] elem_out,
  input  logic        ext_we,
  input  logic [4:0]  ext_widx,
  input  logic [31:0] ext_wdata,
  input  logic [4:0]  ext_ridx,
  output logic [31:0] ext_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    fd_q, fd_d;
  logic [5:0]    inst_q, inst_d;
  logic [31:0]   fs_q, fs_d;
  logic [31:0]   ft_q, ft_d;
  logic          err_q, err_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   regs_q [32];
  logic [31:0]   regs_d [32];
  logic [31:0]   fs_byp, ft_byp;

  // Operand read sees a same-cycle external write to the source index.
  assign fs_byp = (ext_we && ext_widx == req_fs) ? ext_wdata : regs_q[req_fs];
  assign ft_byp = (ext_we && ext_widx == req_ft) ? ext_wdata : regs_q[req_ft];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fd_d    = fd_q;
    inst_d  = inst_q;
    fs_d    = fs_q;
    ft_d    = ft_q;
    err_d   = err_q;
    data_d  = data_q;
    regs_d  = regs_q;
    if (ext_we) regs_d[ext_widx] = ext_wdata;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          inst_d = req_inst_num;
          fd_d   = req_fd;
          fs_d   = fs_byp;
          ft_d   = ft_byp;
          cnt_d  = '0;
          if (req_inst_num >= 6'd54) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            data_d  = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Writeback is applied after ext write so it wins a same-index clash.
        if (elem_completed) begin
          regs_d[fd_q] = elem_out;
          data_d       = elem_out;
          err_d        = 1'b0;
          state_d      = DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fd_q    <= '0;
      inst_q  <= '0;
      fs_q    <= '0;
      ft_q    <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      inst_q  <= inst_d;
      fs_q    <= fs_d;
      ft_q    <= ft_d;
      err_q   <= err_d;
      data_q  <= data_d;
      regs_q  <= regs_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_error    = err_q;
  assign resp_data     = data_q;
  assign elem_reset    = (state_q != RUN);
  assign elem_inst_num = inst_q;
  assign elem_fs       = fs_q;
  assign elem_ft       = ft_q;
  assign ext_rdata     = regs_q[ext_ridx];

endmodule
